// File: rtl/sync_pkg.sv
// Shared definitions for the four-input synchronous join.
//   join_state_e         : join FSM states (COLLECT -> REQ -> RELEASE -> COLLECT)
//   SYNC_STAGES_DEFAULT  : default synchronizer depth per asynchronous input
//   CNT_W_DEFAULT        : default width of the completed-join counter
package sync_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int CNT_W_DEFAULT       = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } join_state_e;

endpackage

// File: rtl/join4_sync_if.sv
// Handshake bundle between four producers, one consumer and the join block.
//   req_in1_i..req_in4_i : four-phase requests from producers 1..4
//   ack_in1_o..ack_in4_o : acknowledges back to producers 1..4
//   req_out_o            : joined request to the consumer
//   ack_out_i            : consumer acknowledge
//   txn_count_o          : completed-join counter (CNT_W bits)
//   err_o                : sticky protocol-violation flag
// Modports: master = producers/consumer side, slave = join block side.
interface join4_sync_if
    import sync_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             req_in1_i;
    logic             req_in2_i;
    logic             req_in3_i;
    logic             req_in4_i;
    logic             ack_in1_o;
    logic             ack_in2_o;
    logic             ack_in3_o;
    logic             ack_in4_o;
    logic             req_out_o;
    logic             ack_out_i;
    logic [CNT_W-1:0] txn_count_o;
    logic             err_o;

    modport master (
        output req_in1_i, req_in2_i, req_in3_i, req_in4_i, ack_out_i,
        input  ack_in1_o, ack_in2_o, ack_in3_o, ack_in4_o,
        input  req_out_o, txn_count_o, err_o
    );

    modport slave (
        input  req_in1_i, req_in2_i, req_in3_i, req_in4_i, ack_out_i,
        output ack_in1_o, ack_in2_o, ack_in3_o, ack_in4_o,
        output req_out_o, txn_count_o, err_o
    );

endinterface

// File: rtl/sync_ff.sv
// Single-bit synchronizer chain, STAGES flops deep, cleared by reset.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output (last flop of the chain)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_reg[STAGES-1];

endmodule

// File: rtl/join4_sync.sv
// Four-input four-phase join, implemented as a clocked FSM behind
// synchronizers on every asynchronous handshake input.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (all outputs forced to 0)
//   bus    : join4_sync_if.slave handshake bundle
// Parameters: SYNC_STAGES (2..4) synchronizer depth, CNT_W counter width.
module join4_sync
    import sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    join4_sync_if.slave bus
);

    logic [3:0] req_async;
    logic [3:0] s_req;
    logic       s_ack;

    join_state_e      state_reg, state_next;
    logic [3:0]       arrived_reg, arrived_next;
    logic [3:0]       ack_reg, ack_next;
    logic             req_out_reg, req_out_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_reg, err_next;

    logic [3:0]       arrived_set;

    assign req_async = {bus.req_in4_i, bus.req_in3_i, bus.req_in2_i, bus.req_in1_i};

    for (genvar gi = 0; gi < 4; gi++) begin : g_req_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (req_async[gi]),
            .q_o   (s_req[gi])
        );
    end

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (bus.ack_out_i),
        .q_o   (s_ack)
    );

    // A channel arrives whenever its request is up and it is not being acked;
    // this also catches producers that re-raise early during RELEASE.
    assign arrived_set = arrived_reg | (s_req & ~ack_reg);

    always_comb begin
        state_next   = state_reg;
        arrived_next = arrived_set;
        ack_next     = ack_reg;
        req_out_next = req_out_reg;
        count_next   = count_reg;
        // An arrived channel whose request is now low withdrew before being
        // acked; a consumer ack while nothing is requested is also illegal.
        // Both only flag, they never steer the FSM.
        err_next     = err_reg | (|(arrived_reg & ~s_req))
                               | ((state_reg == COLLECT) && s_ack);

        case (state_reg)
            COLLECT: begin
                if (&arrived_set) begin
                    state_next   = REQ;
                    req_out_next = 1'b1;
                end
            end
            REQ: begin
                if (s_ack) begin
                    state_next   = RELEASE;
                    req_out_next = 1'b0;
                    ack_next     = 4'hF;
                    arrived_next = 4'h0;
                    count_next   = count_reg + CNT_W'(1);
                end
            end
            RELEASE: begin
                // Each producer's ack drops as soon as that producer lets go.
                ack_next = ack_reg & s_req;
                if ((ack_reg == 4'h0) && !s_ack) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= COLLECT;
            arrived_reg <= 4'h0;
            ack_reg     <= 4'h0;
            req_out_reg <= 1'b0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            arrived_reg <= arrived_next;
            ack_reg     <= ack_next;
            req_out_reg <= req_out_next;
            count_reg   <= count_next;
            err_reg     <= err_next;
        end
    end

    assign bus.ack_in1_o   = ack_reg[0];
    assign bus.ack_in2_o   = ack_reg[1];
    assign bus.ack_in3_o   = ack_reg[2];
    assign bus.ack_in4_o   = ack_reg[3];
    assign bus.req_out_o   = req_out_reg;
    assign bus.txn_count_o = count_reg;
    assign bus.err_o       = err_reg;

endmodule

// File: tb/tb_join4_sync.sv
// Directed testbench for join4_sync. A second instance with a 3-bit counter
// shares the stimulus so counter wrap-around is reached in a few joins.
module tb_join4_sync;
    import sync_pkg::*;

    localparam int WRAP_W = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'h0;
    logic       ack_out = 1'b0;
    logic [3:0] acks;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    join4_sync_if #(.CNT_W(16))     bus ();
    join4_sync_if #(.CNT_W(WRAP_W)) bus_w ();

    assign bus.req_in1_i   = req[0];
    assign bus.req_in2_i   = req[1];
    assign bus.req_in3_i   = req[2];
    assign bus.req_in4_i   = req[3];
    assign bus.ack_out_i   = ack_out;
    assign bus_w.req_in1_i = req[0];
    assign bus_w.req_in2_i = req[1];
    assign bus_w.req_in3_i = req[2];
    assign bus_w.req_in4_i = req[3];
    assign bus_w.ack_out_i = ack_out;

    assign acks = {bus.ack_in4_o, bus.ack_in3_o, bus.ack_in2_o, bus.ack_in1_o};

    join4_sync #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    join4_sync #(.SYNC_STAGES(2), .CNT_W(WRAP_W)) dut_wrap (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_w.slave)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("pass %s: %0h", tag, got);
        end
    endtask

    task automatic wait_req_out(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.req_out_o === 1'b1) break;
            tick(1);
        end
        check_value(tag, 32'(bus.req_out_o), 32'd1);
    endtask

    // Consumer side of a join already in REQ, then producers and consumer
    // withdraw so the FSM returns to COLLECT.
    task automatic finish_join(input string tag, input int exp_count);
        ack_out = 1'b1;
        tick(2);
        check_value({tag, "_ack_early"}, 32'(acks), 32'h0);
        check_value({tag, "_req_held"}, 32'(bus.req_out_o), 32'd1);
        tick(1);
        check_value({tag, "_ack_rise"}, 32'(acks), 32'hF);
        check_value({tag, "_req_fall"}, 32'(bus.req_out_o), 32'd0);
        check_value({tag, "_count"}, 32'(bus.txn_count_o), 32'(exp_count));
        check_value({tag, "_wrap_count"}, 32'(bus_w.txn_count_o), 32'(exp_count % (1 << WRAP_W)));
        req = 4'h0;
        tick(3);
        check_value({tag, "_ack_clear"}, 32'(acks), 32'h0);
        ack_out = 1'b0;
        tick(3);
        check_value({tag, "_collect"}, 32'(dut.state_reg), 32'(COLLECT));
    endtask

    // Requests rise after edges 0/3/5/9; the joined request must appear at edge 12.
    task automatic staggered_join(input string tag);
        req[0] = 1'b1;
        tick(3);
        req[1] = 1'b1;
        tick(2);
        req[2] = 1'b1;
        tick(4);
        req[3] = 1'b1;
        tick(1);
        check_value({tag, "_e10"}, 32'(bus.req_out_o), 32'd0);
        tick(1);
        check_value({tag, "_e11"}, 32'(bus.req_out_o), 32'd0);
        tick(1);
        check_value({tag, "_e12"}, 32'(bus.req_out_o), 32'd1);
        check_value({tag, "_acks_low"}, 32'(acks), 32'h0);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_value("rst_req_out", 32'(bus.req_out_o), 32'd0);
        check_value("rst_acks", 32'(acks), 32'h0);
        check_value("rst_count", 32'(bus.txn_count_o), 32'd0);
        check_value("rst_err", 32'(bus.err_o), 32'd0);
        check_value("rst_state", 32'(dut.state_reg), 32'(COLLECT));
        rst_n = 1'b1;

        // Scenario 1 and 2: staggered arrival, then full handshake
        staggered_join("s1");
        finish_join("s2", 1);

        // Scenario 3: early re-raise of req2 during RELEASE
        req = 4'hF;
        wait_req_out("s3_join_a", 6);
        ack_out = 1'b1;
        tick(3);
        check_value("s3_acks_high", 32'(acks), 32'hF);
        check_value("s3_count_a", 32'(bus.txn_count_o), 32'd2);
        req = 4'h0;
        tick(3);
        check_value("s3_acks_low", 32'(acks), 32'h0);
        check_value("s3_in_release", 32'(dut.state_reg), 32'(RELEASE));
        req[1] = 1'b1;
        tick(3);
        check_value("s3_arrived2", 32'(dut.arrived_reg), 32'h2);
        ack_out = 1'b0;
        tick(3);
        check_value("s3_back_collect", 32'(dut.state_reg), 32'(COLLECT));
        check_value("s3_no_req_yet", 32'(bus.req_out_o), 32'd0);
        req = 4'hF;
        tick(2);
        check_value("s3_req_early", 32'(bus.req_out_o), 32'd0);
        tick(1);
        check_value("s3_req_join_b", 32'(bus.req_out_o), 32'd1);
        finish_join("s3_b", 3);

        // Scenario 4: run the narrow counter up to all-ones and wrap it
        for (int j = 4; j <= 8; j++) begin
            req = 4'hF;
            tick(3);
            check_value($sformatf("s4_req_%0d", j), 32'(bus.req_out_o), 32'd1);
            finish_join($sformatf("s4_j%0d", j), j);
        end

        // Scenario 5: req3 withdrawn before acknowledge
        req[2] = 1'b1;
        tick(3);
        check_value("s5_arrived3", 32'(dut.arrived_reg), 32'h4);
        check_value("s5_err_clear", 32'(bus.err_o), 32'd0);
        req[2] = 1'b0;
        tick(3);
        check_value("s5_err_set", 32'(bus.err_o), 32'd1);
        check_value("s5_req_out", 32'(bus.req_out_o), 32'd0);
        check_value("s5_arrived_kept", 32'(dut.arrived_reg), 32'h4);
        req = 4'b1011;
        tick(3);
        check_value("s5_join_req", 32'(bus.req_out_o), 32'd1);
        finish_join("s5", 9);
        check_value("s5_err_sticky", 32'(bus.err_o), 32'd1);

        // Scenario 6: asynchronous reset while in RELEASE with acks high
        req = 4'hF;
        wait_req_out("s6_join_req", 6);
        ack_out = 1'b1;
        tick(3);
        check_value("s6_acks_high", 32'(acks), 32'hF);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("s6_async_acks", 32'(acks), 32'h0);
        check_value("s6_async_req_out", 32'(bus.req_out_o), 32'd0);
        check_value("s6_async_count", 32'(bus.txn_count_o), 32'd0);
        check_value("s6_async_err", 32'(bus.err_o), 32'd0);
        check_value("s6_async_wrap_count", 32'(bus_w.txn_count_o), 32'd0);
        req = 4'h0;
        ack_out = 1'b0;
        tick(2);
        check_value("s6_state", 32'(dut.state_reg), 32'(COLLECT));
        check_value("s6_arrived", 32'(dut.arrived_reg), 32'h0);
        rst_n = 1'b1;
        staggered_join("s6_rejoin");
        finish_join("s6_done", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
